// File: rtl/pipe_buf.sv
// pipe_buf: valid/ready pipeline buffer holding up to DEPTH payloads of WIDTH bits.
// in_ready_o is a function of registered occupancy (and flush) only, so the ready
// chain between pipeline stages is cut here. flush_i empties the buffer synchronously.
// Optional feature macro: PIPE_BUF_BYPASS_EN -- when defined, an empty buffer passes
// in_data_i straight to out_data_o in the same cycle.
module pipe_buf #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [CW-1:0]    count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

   // Circular increment; pointers wrap from DEPTH-1 to 0 so any DEPTH is legal.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == LAST_C) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1'b1);
      end
   endfunction

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q,  count_d;

   logic not_empty_s;
   logic in_ready_s;
   logic out_valid_s;
   logic byp_s;
   logic push_s;
   logic pop_s;

   // Handshake decode: ready from registered occupancy, valid from occupancy or bypass.
   always_comb begin
      not_empty_s = (count_q != {CW{1'b0}});
      in_ready_s  = (count_q < DEPTH_C) & ~flush_i;
`ifdef PIPE_BUF_BYPASS_EN
      byp_s       = ~not_empty_s & in_valid_i & ~flush_i;
`else
      byp_s       = 1'b0;
`endif
      out_valid_s = (not_empty_s | byp_s) & ~flush_i;
      // A bypassed payload taken downstream the same cycle never touches storage.
      push_s      = in_valid_i & in_ready_s & ~(byp_s & out_ready_i);
      // Stored-entry pop only; a bypass transfer leaves rd_ptr alone.
      pop_s       = not_empty_s & out_valid_s & out_ready_i;
   end

   // Output drive: head entry when occupied, bypassed input when allowed, else zeros.
   always_comb begin
      in_ready_o  = in_ready_s;
      out_valid_o = out_valid_s;
      count_o     = count_q;
      if (not_empty_s) begin
         out_data_o = mem_q[rd_ptr_q];
      end else if (byp_s) begin
         out_data_o = in_data_i;
      end else begin
         out_data_o = {WIDTH{1'b0}};
      end
   end

   // Next-state for pointers and occupancy; flush overrides everything.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register; asynchronous reset empties the buffer immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage write; contents are not reset and survive flush untouched.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= in_data_i;
      end
   end

endmodule

// File: tb/tb_pipe_buf.sv
// Scoreboard bench for pipe_buf: instance A (DEPTH=2) runs directed scenarios,
// instance B (DEPTH=3) runs a fixed valid/ready pattern across pointer wrap.
module tb_pipe_buf;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

`ifdef PIPE_BUF_BYPASS_EN
   localparam int STREAM_CNT = 0;
   localparam int BYP = 1;
`else
   localparam int STREAM_CNT = 1;
   localparam int BYP = 0;
`endif

   // Instance A: DEPTH=2, WIDTH=32
   logic        a_flush = 1'b0, a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
   logic [31:0] a_in_data = 32'h0, a_out_data;
   logic [1:0]  a_count;

   // Instance B: DEPTH=3, WIDTH=32
   logic        b_flush = 1'b0, b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
   logic [31:0] b_in_data = 32'h0, b_out_data;
   logic [1:0]  b_count;

   pipe_buf #(.WIDTH(32), .DEPTH(2)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
      .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
      .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
      .count_o(a_count));

   pipe_buf #(.WIDTH(32), .DEPTH(3)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
      .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
      .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
      .count_o(b_count));

   int n_pass = 0;
   int n_tot  = 0;
   logic [31:0] a_q[$];
   logic [31:0] b_q[$];
   int a_pops = 0;
   int b_pops = 0;
   int b_pushes = 0;
   bit b_acc = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One clock: record an accepted A push at the negedge, return at posedge+1.
   task automatic tick();
      @(negedge clk);
      if (rst_n && a_in_valid && a_in_ready) a_q.push_back(a_in_data);
      @(posedge clk);
      #1;
   endtask

   // Monitor A: compare every output handshake against the scoreboard head.
   always begin
      @(negedge clk);
      #2;
      if (rst_n && a_out_valid && a_out_ready) begin
         a_pops++;
         if (a_q.size() == 0) begin
            n_tot++;
            $display("FAIL a_unexpected_pop: got %0h expected none", a_out_data);
         end else begin
            chk("a_data", a_out_data, a_q.pop_front());
         end
      end
   end

   // Scoreboard B: occupancy check, record accepted push, then compare any pop.
   always begin
      @(negedge clk);
      if (!rst_n) begin
         b_q.delete();
         b_acc = 1'b0;
      end else begin
         chk("b_count", 32'(b_count), 32'(b_q.size()));
         b_acc = b_in_valid && b_in_ready;
         if (b_acc) begin
            b_q.push_back(b_in_data);
            b_pushes++;
         end
         if (b_out_valid && b_out_ready) begin
            b_pops++;
            if (b_q.size() == 0) begin
               n_tot++;
               $display("FAIL b_unexpected_pop: got %0h expected none", b_out_data);
            end else begin
               chk("b_data", b_out_data, b_q.pop_front());
            end
         end
      end
   end

   initial begin
      bit [15:0] vpat;
      bit [15:0] rpat;
      logic [31:0] b_seq;
      vpat  = 16'b1011_0111_1101_1110;
      rpat  = 16'b0110_1011_1001_0111;
      b_seq = 32'd1;

      // Reset state
      @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(a_in_ready), 32'd1);
      chk("rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_out_data", a_out_data, 32'h0);
      chk("rst_count", 32'(a_count), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Reset asserted mid-stream with two entries held
      a_in_valid = 1'b1; a_in_data = 32'hD1; tick();
      a_in_data = 32'hD2; tick();
      a_in_valid = 1'b0;
      chk("pre_rst_count", 32'(a_count), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(a_in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
      chk("mid_rst_count", 32'(a_count), 32'd0);
      chk("mid_rst_out_data", a_out_data, 32'h0);
      a_q.delete();
      tick();
      rst_n = 1'b1;
      tick();
      a_in_valid = 1'b1; a_in_data = 32'hA5; tick();
      a_in_valid = 1'b0;
      chk("post_rst_valid", 32'(a_out_valid), 32'd1);
      chk("post_rst_data", a_out_data, 32'hA5);
      a_out_ready = 1'b1;
      tick();

      // Back-to-back stream 0x1..0x10 with downstream always ready
      a_pops = 0;
      for (int v = 1; v <= 16; v++) begin
         a_in_valid = 1'b1;
         a_in_data  = 32'(v);
         chk("stream_ready", 32'(a_in_ready), 32'd1);
         tick();
         chk("stream_count", 32'(a_count), 32'(STREAM_CNT));
      end
      a_in_valid = 1'b0;
      tick();
      chk("stream_pops", 32'(a_pops), 32'd16);
      chk("stream_drained", 32'(a_count), 32'd0);

      // Backpressure until full, then full + simultaneous pop
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 32'h11; tick();
      a_in_data = 32'h22; tick();
      a_in_data = 32'h33;
      chk("full_in_ready", 32'(a_in_ready), 32'd0);
      tick();
      chk("full_count", 32'(a_count), 32'd2);
      chk("full_head", a_out_data, 32'h11);
      a_out_ready = 1'b1;
      tick();
      chk("full_pop_count", 32'(a_count), 32'd1);
      chk("full_pop_ready", 32'(a_in_ready), 32'd1);
      chk("full_pop_head", a_out_data, 32'h22);
      tick();
      chk("refill_count", 32'(a_count), 32'd1);
      chk("refill_head", a_out_data, 32'h33);
      a_in_valid = 1'b0;
      tick();
      chk("bp_drained", 32'(a_count), 32'd0);

      // Flush with push and pop requested in the same cycle
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 32'h44; tick();
      a_in_data = 32'h55; tick();
      a_in_data = 32'h66; a_out_ready = 1'b1; a_flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(a_in_ready), 32'd0);
      chk("flush_out_valid", 32'(a_out_valid), 32'd0);
      tick();
      a_q.delete();
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      #1;
      chk("post_flush_count", 32'(a_count), 32'd0);
      chk("post_flush_valid", 32'(a_out_valid), 32'd0);
      a_in_valid = 1'b1; a_in_data = 32'h77; tick();
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      #1;
      chk("post_flush_head", a_out_data, 32'h77);
      tick();

      // Empty buffer with valid and ready: same-cycle path only with bypass
      a_in_valid = 1'b1; a_in_data = 32'hBEEF;
      #1;
      chk("byp_valid", 32'(a_out_valid), 32'(BYP));
      chk("byp_data", a_out_data, (BYP != 0) ? 32'hBEEF : 32'h0);
      tick();
      a_in_valid = 1'b0;
      chk("byp_count", 32'(a_count), 32'(1 - BYP));
      tick();
      chk("a_sb_empty", 32'(a_q.size()), 32'd0);

      // Instance B: mixed push/pop pattern across pointer wrap
      for (int c = 0; c < 32; c++) begin
         if (!b_in_valid || b_acc) begin
            if (b_acc) b_seq = b_seq + 32'd1;
            b_in_valid = vpat[c % 16];
            b_in_data  = b_seq;
         end
         b_out_ready = rpat[c % 16];
         tick();
      end
      b_in_valid = 1'b0;
      b_out_ready = 1'b1;
      repeat (5) tick();
      chk("b_sb_empty", 32'(b_q.size()), 32'd0);
      chk("b_final_count", 32'(b_count), 32'd0);
      chk("b_pop_total", 32'(b_pops), 32'(b_pushes));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/pipe_buf.md
# pipe_buf

Parametrised valid/ready pipeline buffer placed between any two pipeline stages (IF→ID, ID→EX, EX→MEM). It is the next-generation replacement for the single-entry stage register. It holds up to DEPTH entries of WIDTH bits and supports synchronous flush on redirect. in_ready_o depends only on registered state, which breaks the combinational ready chain between stages. An optional same-cycle bypass removes the empty-buffer latency.

## Interface
- WIDTH, 64, payload width in bits (≥1); the pipe payload structs are packed into it
- DEPTH, 2, number of entries (≥1); DEPTH≥2 is required for full throughput
- CW, $clog2(DEPTH+1), width of count_o (derived, not overridden)
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush (pipeline redirect); highest priority
- in_valid_i  in  1  upstream has a payload
- in_ready_o  out  1  buffer accepts a payload this cycle
- in_data_i  in  WIDTH  upstream payload
- out_valid_o  out  1  buffer presents a payload
- out_ready_i  in  1  downstream accepts
- out_data_o  out  WIDTH  payload at head
- count_o  out  CW  current occupancy, 0..DEPTH

## Operation
- Storage is a circular buffer of DEPTH entries with rd_ptr and wr_ptr (0..DEPTH-1) and a count register.
- Pointers wrap from DEPTH-1 to 0. Non-power-of-2 DEPTH is legal.
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- in_ready_o = (count < DEPTH) & ~flush_i. There is no path from out_ready_i to in_ready_o. When full, a simultaneous pop does not enable a push that cycle.
- out_valid_o = (count != 0) & ~flush_i.
- out_data_o = mem[rd_ptr] when count != 0, else all zeros.
- Push writes mem[wr_ptr] and increments wr_ptr. Pop increments rd_ptr.
- count updates by +1 (push only), −1 (pop only), or 0 (both or neither).
- flush_i = 1: next state is count=0 and rd_ptr=wr_ptr=0. Any push or pop that cycle is suppressed because in_ready_o and out_valid_o are forced to 0. Entry contents are left unchanged.
- Order is strict FIFO. No payload is duplicated or dropped except by flush.

## Timing
- Reset (rst_ni=0, asynchronous) sets count, rd_ptr and wr_ptr to 0. Outputs during and after reset:
  - in_ready_o = 1
  - out_valid_o = 0
  - out_data_o = 0
  - count_o = 0
- The storage array is not reset.
- Reset asserted mid-transfer discards all contents immediately. No handshake completes in a cycle where rst_ni=0.
- Without bypass, latency is 1 cycle: a payload pushed at edge N is visible on out_* after edge N.
- Throughput with DEPTH≥2 is 1 payload/cycle. With DEPTH=1, alternating cycles at most.
- Upstream must hold in_valid_i and in_data_i stable until in_ready_o. The block holds out_valid_o and out_data_o stable until out_ready_i, except on flush or reset.
- Empty + push: out_valid_o rises the next cycle.
- Full + pop: in_ready_o rises the next cycle.
- Flush + push in the same cycle: the push is lost. The buffer is empty the next cycle.

## Configuration
- PIPE_BUF_BYPASS_EN defined: when count==0 and flush_i=0:
  - out_valid_o = in_valid_i and out_data_o = in_data_i (combinational).
  - If out_ready_i=1, the payload transfers in the same cycle and is not written to storage; pointers and count are unchanged.
  - If out_ready_i=0, the payload is pushed normally.
  - Latency is 0 cycles when empty. in_ready_o is unchanged (still registered-only).
- PIPE_BUF_BYPASS_EN undefined: no combinational in→out path; behaviour exactly as in Operation and Timing.

## Test plan
- Reset: rst_ni=0 mid-stream with count=2 → outputs immediately in_ready_o=1, out_valid_o=0, count_o=0, out_data_o=0; after release, the first push of 0xA5 appears on out_data_o the next cycle.
- Stream: DEPTH=2, WIDTH=32, push 0x1..0x10 back-to-back with out_ready_i=1 → outputs 0x1..0x10 in order, one per cycle after the first, count_o steady at 1 (0 with bypass).
- Backpressure/full: out_ready_i=0, push 0x11, 0x22, 0x33 → 0x33 held since in_ready_o=0 after 2 pushes, count_o=2; raise out_ready_i → pops 0x11, then 0x22 with 0x33 pushed; order 0x11, 0x22, 0x33.
- Full with simultaneous pop: count=DEPTH, in_valid_i=1, out_ready_i=1 → pop only, count_o becomes DEPTH−1, push completes the following cycle.
- Flush: count=2 with push and pop asserted and flush_i=1 → in_ready_o=0, out_valid_o=0 that cycle; next cycle count_o=0, out_valid_o=0; the next push 0x77 emerges first.
- Wrap/bypass: DEPTH=3, run 10 push/pop mixes crossing pointer wrap → scoreboard match. With PIPE_BUF_BYPASS_EN, empty + in_valid_i=1 + out_ready_i=1 with 0xBEEF → out_data_o=0xBEEF the same cycle and count_o stays 0.
